// File: rtl/usr_cmd_sequencer.sv
// Command front-end for the 4-bit universal shift register: expands one
// load / shift / rotate / nop command into per-cycle sel and data controls.
module usr_cmd_sequencer #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic [3:0]       cmd_data,
  input  logic             cmd_fill,
  input  logic [3:0]       reg_q,
  output logic [1:0]       sel,
  output logic [3:0]       parallel_input,
  output logic             left_input,
  output logic             right_input,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic [3:0]       data_r;
  logic             fill_r;
  logic             xfer;
  logic             is_shift_op;

  // Rotates only feed back the end bits; the middle bits are deliberately unused.
  logic unused_reg_q_mid;
  assign unused_reg_q_mid = ^reg_q[2:1];

  assign xfer        = cmd_valid && cmd_ready;
  assign is_shift_op = (cmd_op == OP_SHR) || (cmd_op == OP_SHL) ||
                       (cmd_op == OP_ROR) || (cmd_op == OP_ROL);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD)                            state_nxt = LOAD;
          else if (is_shift_op && (cmd_amount != '0))       state_nxt = SHIFT;
          else                                              state_nxt = DONE;
        end
      end
      LOAD:    state_nxt = DONE;
      SHIFT:   if (cnt == AMT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Right-moving ops have op[0]=1, rotates have op[2]=1.
  always_comb begin
    sel            = SEL_HOLD;
    parallel_input = '0;
    left_input     = 1'b0;
    right_input    = 1'b0;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      LOAD: begin
        sel            = SEL_LOAD;
        parallel_input = data_r;
      end
      SHIFT: begin
        if (op_r[0]) begin
          sel         = SEL_RIGHT;
          right_input = op_r[2] ? reg_q[0] : fill_r;
        end else begin
          sel        = SEL_LEFT;
          left_input = op_r[2] ? reg_q[3] : fill_r;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      data_r <= '0;
      fill_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
        fill_r <= cmd_fill;
        cnt    <= cmd_amount;
      end else if (state == SHIFT) begin
        cnt <= cnt - AMT_W'(1);
      end
    end
  end

endmodule

// File: doc/usr_cmd_sequencer.md
Name: usr_cmd_sequencer

Overview:
Command front-end that sits directly upstream of the 4-bit universal shift register. It drives that register's `sel`, `parallel_input`, `left_input` and `right_input`, and takes the register's `out` back as `reg_q`. It accepts one command at a time over a valid/ready handshake: load, shift with fill bit, rotate, or nop. It expands each command into the correct per-cycle register controls and pulses `done` once the register holds the result.

Parameters:
AMT_W, 3, width of `cmd_amount`. Shift/rotate counts run 0..2^AMT_W-1.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (IDLE only)
cmd_op  input  3  000 nop, 001 shift right with fill, 010 shift left with fill, 011 load, 101 rotate right, 110 rotate left; 100/111 treated as nop
cmd_amount  input  AMT_W  number of single-bit steps for shift/rotate; ignored for load/nop
cmd_data  input  4  load value
cmd_fill  input  1  serial fill bit for shift ops
reg_q  input  4  current shift-register `out` (feedback)
sel  output  2  to shift register: 00 hold, 01 right, 10 left, 11 load
parallel_input  output  4  to shift register
left_input  output  1  to shift register (enters LSB on sel=10)
right_input  output  1  to shift register (enters MSB on sel=01)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: command complete, `reg_q` already shows the result

Behaviour:
- Single clock domain. All state updates on the rising edge of `clk`. `clr` is synchronous, active-high, and has priority over everything else.
- Reset values:
  - state = IDLE, counter = 0, latched fields = 0.
  - sel=00, parallel_input=0, left_input=0, right_input=0, busy=0, done=0, cmd_ready=1.
- Handshake:
  - A transfer occurs on an edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready = (state==IDLE).
  - On transfer, the sequencer latches op, amount, data and fill. Inputs are don't-care at any other time.
- States:
  - IDLE:
    - Outputs: sel=00, cmd_ready=1.
    - On transfer with op=load, go to LOAD.
    - On transfer with a shift/rotate op and amount != 0, set cnt=amount and go to SHIFT.
    - On transfer with nop, a reserved op, or amount=0, go straight to DONE (no register change).
  - LOAD:
    - Outputs: sel=11, parallel_input=latched data, for exactly one cycle.
    - Next state: DONE.
  - SHIFT:
    - sel=01 for right ops, 10 for left ops.
    - Serial inputs:
      - Shift right: right_input = fill.
      - Shift left: left_input = fill.
      - Rotate right: right_input = reg_q[0], combinational from `reg_q`.
      - Rotate left: left_input = reg_q[3], combinational from `reg_q`.
      - The unused serial input is held at 0.
    - Each cycle cnt decrements. When cnt==1 on an edge, go to DONE.
  - DONE:
    - Outputs: done=1, sel=00, cmd_ready=0.
    - Next state: IDLE.
- Outside LOAD, parallel_input=0. Outside SHIFT, both serial inputs are 0.
- Latency, with transfer at edge E0:
  - Load: register updates at E1; done is high in the cycle after E1.
  - Shift/rotate by N: register updates at E1..EN; done is high in the cycle after EN.
  - Nop: done is high in the cycle after E0.
- Back-to-back throughput: the next command can be accepted at the edge following the done cycle. A load therefore takes a 3-cycle period per command.
- Amount >4:
  - Shifts are not clamped. For example, shift by 7 fills all bits with fill and takes 7 cycles.
  - Rotates are not reduced modulo 4. For example, rotate by 4 restores the original value and takes 4 cycles.
- Reset mid-command: the command is abandoned, no done is pulsed, and all outputs return to reset values on the next edge. The shift register shares `clr` and clears in the same edge.
- cmd_valid deasserting in IDLE is legal; no transfer occurs.

Test Plan:
1. Reset then load: assert clr for 2 cycles; check reset values. Send load data=4'b1010 → sel=11 for exactly 1 cycle; reg_q=1010 with done=1 in the cycle after; busy high for 2 cycles.
2. Rotate right by 1, reg_q=1001 → sel=01, right_input=1 for one cycle; reg_q=1100 at done. Rotate left by 2 from 1100 → reg_q=0011, sel=10 for exactly 2 cycles.
3. Shift left by 3 with fill=1 from 0000 → left_input=1 for 3 cycles; reg_q=0111. Shift right by 7 with fill=0 from 1111 → 7 SHIFT cycles; reg_q=0000.
4. Amount=0 rotate, nop, and op=100: each gives done in the cycle after transfer; sel stays 00 throughout; reg_q unchanged.
5. Hold cmd_valid=1 continuously with 3 queued loads → exactly one transfer per IDLE cycle; cmd_ready=0 in LOAD/DONE; 3 done pulses over 9 cycles.
6. Assert clr during the 2nd cycle of a shift-by-4 → no done pulse; next edge gives state IDLE, sel=00, cmd_ready=1, reg_q=0000; a new load is then accepted normally.
